priority_encoder_al: RTL and testbench



---
 rtl/priority_encoder_al.sv | 105 ++++++++++
 tb/tb_priority_encoder_al.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_al.sv
// Active-low 16-to-4 sequential priority encoder.
// Latches falling edges as pending events and presents the highest under valid/ack.
module priority_encoder_al (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] in,
  input  logic        ack,
  output logic [3:0]  code,
  output logic        valid,
  output logic [15:0] pending,
  output logic        overflow
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] s_q;
  logic [15:0] pend_q;
  logic [15:0] pend_d;
  logic [3:0]  code_q;
  logic        ovf_q;
  logic        ovf_d;
  logic        load;
  logic [15:0] fall;
  logic [15:0] set_v;
  logic [15:0] clr_v;
  logic [3:0]  hi_idx;

  assign fall  = s_q & ~in;
  assign set_v = en ? 16'h0000 : fall;

  // Ack clears only the bit currently presented.
  always_comb begin
    clr_v = '0;
    if (state_q == PRESENT && ack) begin
      clr_v[code_q] = 1'b1;
    end
  end

  // Highest set index of the pending bitmap.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (pend_q[i]) begin
        hi_idx = 4'(i);
      end
    end
  end

  // Set wins over ack-clear; an edge on a bit being acked is not an overflow.
  always_comb begin
    pend_d = (pend_q & ~clr_v) | set_v;
    ovf_d  = ovf_q | (|(set_v & pend_q & ~clr_v));
  end

  // Next-state logic for the presentation handshake.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!en && (pend_q != 16'h0000)) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, sample, pending, code and overflow registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= 16'hFFFF;
      pend_q  <= '0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= in;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      if (load) begin
        code_q <= hi_idx;
      end
    end
  end

  assign code     = code_q;
  assign valid    = (state_q == PRESENT);
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_priority_encoder_al.sv
// Bench for priority_encoder_al: directed table, async reset sequence,
// and randomized traffic against a behavioural event model.
module tb_priority_encoder_al;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [15:0] in;
  logic        ack;
  logic [3:0]  code;
  logic        valid;
  logic [15:0] pending;
  logic        overflow;

  priority_encoder_al dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .in       (in),
    .ack      (ack),
    .code     (code),
    .valid    (valid),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] vin;
    logic        ven;
    logic        vack;
    logic [3:0]  xcode;
    logic        xvalid;
    logic [15:0] xpend;
    logic        xovf;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_miss;

  bit   m_s[16];
  bit   m_pend[16];
  bit   m_valid;
  bit   m_ovf;
  int   m_code;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_s[i]    = 1'b1;
      m_pend[i] = 1'b0;
    end
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_code  = 0;
  endfunction

  function automatic void model_edge(logic [15:0] vin, logic ven, logic vack);
    bit np[16];
    int clr;
    int hi;
    clr = (m_valid && vack) ? m_code : -1;
    hi  = -1;
    for (int i = 0; i < 16; i++) begin
      if (m_pend[i]) hi = i;
    end
    for (int i = 0; i < 16; i++) begin
      bit f;
      f = m_s[i] && !vin[i];
      if (!ven && f) begin
        if (m_pend[i] && i != clr) m_ovf = 1'b1;
        np[i] = 1'b1;
      end else if (i == clr) begin
        np[i] = 1'b0;
      end else begin
        np[i] = m_pend[i];
      end
    end
    if (m_valid) begin
      if (vack) m_valid = 1'b0;
    end else if (!ven && hi >= 0) begin
      m_valid = 1'b1;
      m_code  = hi;
    end
    for (int i = 0; i < 16; i++) begin
      m_pend[i] = np[i];
      m_s[i]    = vin[i];
    end
  endfunction

  function automatic logic [15:0] model_pend();
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = m_pend[i];
    return p;
  endfunction

  task automatic check(string name, logic [3:0] xc, logic xv,
                       logic [15:0] xp, logic xo);
    n_vec++;
    if (code !== xc || valid !== xv || pending !== xp || overflow !== xo) begin
      n_miss++;
      $display("FAIL %s: got code=%0d valid=%0b pending=%h ovf=%0b, want code=%0d valid=%0b pending=%h ovf=%0b",
               name, code, valid, pending, overflow, xc, xv, xp, xo);
    end
  endtask

  task automatic tick(logic [15:0] vin, logic ven, logic vack);
    in  = vin;
    en  = ven;
    ack = vack;
    @(posedge clk);
    model_edge(vin, ven, vack);
    #1;
  endtask

  function automatic void add(logic [15:0] vin, logic ven, logic vack,
                              logic [3:0] xc, logic xv, logic [15:0] xp,
                              logic xo);
    vec_t v;
    v.vin = vin; v.ven = ven; v.vack = vack;
    v.xcode = xc; v.xvalid = xv; v.xpend = xp; v.xovf = xo;
    tbl.push_back(v);
  endfunction

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    reset_n = 1'b0;
    in      = 16'hFFFF;
    en      = 1'b0;
    ack     = 1'b0;
    model_reset();

    // idle
    for (int i = 0; i < 10; i++) add(16'hFFFF, 0, 0, 0, 0, 16'h0000, 0);
    // single event on line 5
    add(16'hFFDF, 0, 0, 0, 0, 16'h0020, 0);
    add(16'hFFFF, 0, 0, 5, 1, 16'h0020, 0);
    add(16'hFFFF, 0, 1, 5, 0, 16'h0000, 0);
    add(16'hFFFF, 0, 0, 5, 0, 16'h0000, 0);
    // priority, no preemption
    add(16'hFDFB, 0, 0, 5, 0, 16'h0204, 0);
    add(16'hFFFF, 0, 0, 9, 1, 16'h0204, 0);
    add(16'hBFFF, 0, 0, 9, 1, 16'h4204, 0);
    add(16'hFFFF, 0, 0, 9, 1, 16'h4204, 0);
    add(16'hFFFF, 0, 1, 9, 0, 16'h4004, 0);
    add(16'hFFFF, 0, 0, 14, 1, 16'h4004, 0);
    add(16'hFFFF, 0, 1, 14, 0, 16'h0004, 0);
    add(16'hFFFF, 0, 0, 2, 1, 16'h0004, 0);
    add(16'hFFFF, 0, 1, 2, 0, 16'h0000, 0);
    add(16'hFFFF, 0, 0, 2, 0, 16'h0000, 0);
    // enable gating
    add(16'hFFF7, 1, 0, 2, 0, 16'h0000, 0);
    add(16'hFFF7, 1, 0, 2, 0, 16'h0000, 0);
    add(16'hFFF7, 0, 0, 2, 0, 16'h0000, 0);
    add(16'hFFFF, 0, 0, 2, 0, 16'h0000, 0);
    add(16'hFFF7, 0, 0, 2, 0, 16'h0008, 0);
    add(16'hFFFF, 0, 0, 3, 1, 16'h0008, 0);
    add(16'hFFFF, 0, 1, 3, 0, 16'h0000, 0);
    // ack/capture collision on line 7
    add(16'hFF7F, 0, 0, 3, 0, 16'h0080, 0);
    add(16'hFFFF, 0, 0, 7, 1, 16'h0080, 0);
    add(16'hFF7F, 0, 1, 7, 0, 16'h0080, 0);
    add(16'hFFFF, 0, 0, 7, 1, 16'h0080, 0);
    add(16'hFFFF, 0, 1, 7, 0, 16'h0000, 0);
    // overflow on line 0
    add(16'hFFFE, 0, 0, 7, 0, 16'h0001, 0);
    add(16'hFFFF, 0, 0, 0, 1, 16'h0001, 0);
    add(16'hFFFE, 0, 0, 0, 1, 16'h0001, 1);
    add(16'hFFFF, 0, 1, 0, 0, 16'h0000, 1);
    add(16'hFFFF, 0, 0, 0, 0, 16'h0000, 1);
    // en=1 during PRESENT completes handshake, then IDLE holds
    add(16'hEFFF, 0, 0, 0, 0, 16'h1000, 1);
    add(16'hFFFF, 0, 0, 12, 1, 16'h1000, 1);
    add(16'hFFFF, 1, 0, 12, 1, 16'h1000, 1);
    add(16'hFFFF, 1, 1, 12, 0, 16'h0000, 1);
    add(16'hFFFF, 1, 0, 12, 0, 16'h0000, 1);

    #12;
    reset_n = 1'b1;
    check("reset", 0, 0, 16'h0000, 0);

    for (int r = 0; r < tbl.size(); r++) begin
      tick(tbl[r].vin, tbl[r].ven, tbl[r].vack);
      check($sformatf("row%0d", r), tbl[r].xcode, tbl[r].xvalid,
            tbl[r].xpend, tbl[r].xovf);
    end

    // async reset while presenting with pending=8001
    tick(16'h7FFE, 0, 0);
    check("pre8001", 12, 0, 16'h8001, 1);
    tick(16'hFFFF, 0, 0);
    check("pres15", 15, 1, 16'h8001, 1);
    #2;
    reset_n = 1'b0;
    in      = 16'hFFFE;
    #1;
    check("async_rst", 0, 0, 16'h0000, 0);
    @(posedge clk);
    #1;
    check("rst_hold", 0, 0, 16'h0000, 0);
    #1;
    reset_n = 1'b1;
    model_reset();
    tick(16'hFFFE, 0, 0);
    check("rel_e1", 0, 0, 16'h0001, 0);
    tick(16'hFFFE, 0, 0);
    check("rel_e2", 0, 1, 16'h0001, 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] rin;
      logic        ren;
      logic        rack;
      rin  = ~(16'($urandom) & 16'($urandom) & 16'($urandom));
      ren  = ($urandom_range(0, 7) == 0);
      rack = 1'($urandom_range(0, 1));
      tick(rin, ren, rack);
      check($sformatf("rand%0d", c), 4'(m_code), m_valid, model_pend(), m_ovf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
